// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: controller states, requester identity,
// MEM length codes, IO region marker and RAM bus width.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_RD   = 2'd1,
        MC_WR   = 2'd2
    } mc_state_e;

    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_MEM = 1'b1
    } mc_src_e;

    // mem_len_i codes are bytes-1
    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd3;

    // addr[17:16] value that selects the memory-mapped IO region
    localparam logic [1:0] IO_HI_DEF = 2'b11;

    localparam int RAM_BUS_W = 8;

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port byte-RAM arbiter for the IF fetch port and the MEM
// load/store port. Requests are split into byte accesses; read bytes are
// shifted into a 32-bit buffer little-endian and returned with a done pulse.
// Build option: MEMCTRL_IO_STALL_EN holds IO-region stores in IDLE while the
// IO output buffer reports full.
//
// state   | meaning
// --------+-----------------------------------------------------------
// MC_IDLE | bus idle (addr 0, no write); arbitrate, MEM before IF
// MC_RD   | byte reads: issue addr+k, capture byte k one edge later
// MC_WR   | byte writes: addr+k with wdata byte k, write strobe high
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = IO_HI_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req_i,
    input  logic [ADDR_W-1:0]    if_addr_i,
    input  logic                 if_flush_i,
    input  logic                 mem_req_i,
    input  logic                 mem_we_i,
    input  logic [1:0]           mem_len_i,
    input  logic [ADDR_W-1:0]    mem_addr_i,
    input  logic [31:0]          mem_wdata_i,
    input  logic                 io_full_i,
    input  logic [RAM_BUS_W-1:0] ram_din_i,
    output logic [ADDR_W-1:0]    ram_a_o,
    output logic [RAM_BUS_W-1:0] ram_dout_o,
    output logic                 ram_wr_o,
    output logic                 if_done_o,
    output logic [31:0]          if_data_o,
    output logic                 mem_done_o,
    output logic [31:0]          mem_rdata_o
);

    mc_state_e             state_q, state_d;
    mc_src_e               src_q, src_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [1:0]            len_q, len_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           buf_q, buf_d;
    logic [ADDR_W-1:0]     ram_a_q, ram_a_d;
    logic [RAM_BUS_W-1:0]  ram_dout_q, ram_dout_d;
    logic                  ram_wr_q, ram_wr_d;
    logic                  if_done_q, if_done_d;
    logic [31:0]           if_data_q, if_data_d;
    logic                  mem_done_q, mem_done_d;
    logic [31:0]           mem_rdata_q, mem_rdata_d;
    logic                  io_block;
    logic [2:0]            nbytes;

`ifdef MEMCTRL_IO_STALL_EN
    assign io_block = mem_we_i && (mem_addr_i[17:16] == IO_HI) && io_full_i;
`else
    logic unused_io;
    assign unused_io = &{io_full_i, IO_HI};
    assign io_block  = 1'b0;
`endif

    assign nbytes = {1'b0, len_q} + 3'd1;

    // Next-state, bus and response computation; cnt_q is the edge index k
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        ram_a_d     = '0;
        ram_dout_d  = '0;
        ram_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        if_data_d   = if_data_q;
        mem_done_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            MC_IDLE: begin
                // a requester still sees its done pulse this cycle, so hold off
                if (!if_done_q && !mem_done_q) begin
                    if (mem_req_i && !io_block) begin
                        src_d   = SRC_MEM;
                        len_d   = mem_len_i;
                        addr_d  = mem_addr_i;
                        cnt_d   = 3'd1;
                        buf_d   = '0;
                        ram_a_d = mem_addr_i;
                        if (mem_we_i) begin
                            state_d    = MC_WR;
                            ram_dout_d = mem_wdata_i[7:0];
                            wdata_d    = mem_wdata_i >> 8;
                            ram_wr_d   = 1'b1;
                        end else begin
                            state_d = MC_RD;
                        end
                    end else if (if_req_i && !if_flush_i) begin
                        src_d   = SRC_IF;
                        len_d   = LEN_W;
                        addr_d  = if_addr_i;
                        cnt_d   = 3'd1;
                        buf_d   = '0;
                        ram_a_d = if_addr_i;
                        state_d = MC_RD;
                    end
                end
            end
            MC_RD: begin
                if (src_q == SRC_IF && if_flush_i) begin
                    state_d = MC_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q <= nbytes)
                        buf_d = {ram_din_i, buf_q[31:8]};
                    if (cnt_q < nbytes)
                        ram_a_d = addr_q + ADDR_W'(cnt_q);
                    if (cnt_q == nbytes + 3'd1) begin
                        state_d = MC_IDLE;
                        cnt_d   = '0;
                        if (src_q == SRC_IF) begin
                            if_done_d = 1'b1;
                            if_data_d = buf_q;
                        end else begin
                            mem_done_d  = 1'b1;
                            // bytes arrived at the top; align down and zero above len
                            mem_rdata_d = buf_q >> {~len_q, 3'b000};
                        end
                    end
                end
            end
            MC_WR: begin
                if (cnt_q < nbytes) begin
                    ram_a_d    = addr_q + ADDR_W'(cnt_q);
                    ram_dout_d = wdata_q[7:0];
                    wdata_d    = wdata_q >> 8;
                    ram_wr_d   = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                end else begin
                    mem_done_d = 1'b1;
                    state_d    = MC_IDLE;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = MC_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs; reset drops any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MC_IDLE;
            src_q       <= SRC_IF;
            cnt_q       <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            if_data_q   <= '0;
            mem_done_q  <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            if_data_q   <= if_data_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_a_o     = ram_a_q;
    assign ram_dout_o  = ram_dout_q;
    assign ram_wr_o    = ram_wr_q;
    assign if_done_o   = if_done_q;
    assign if_data_o   = if_data_q;
    assign mem_done_o  = mem_done_q;
    assign mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a 256-byte RAM model indexed by the low
// address byte; read data follows the registered RAM address combinationally.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_flush_i = 1'b0;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [1:0]  mem_len_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        io_full_i = 1'b0;
    logic [7:0]  ram_din_i;
    logic [31:0] ram_a_o;
    logic [7:0]  ram_dout_o;
    logic        ram_wr_o;
    logic        if_done_o;
    logic [31:0] if_data_o;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_flush_i (if_flush_i),
        .mem_req_i  (mem_req_i),
        .mem_we_i   (mem_we_i),
        .mem_len_i  (mem_len_i),
        .mem_addr_i (mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .io_full_i  (io_full_i),
        .ram_din_i  (ram_din_i),
        .ram_a_o    (ram_a_o),
        .ram_dout_o (ram_dout_o),
        .ram_wr_o   (ram_wr_o),
        .if_done_o  (if_done_o),
        .if_data_o  (if_data_o),
        .mem_done_o (mem_done_o),
        .mem_rdata_o(mem_rdata_o)
    );

    logic [7:0] ram [0:255];
    assign ram_din_i = ram[ram_a_o[7:0]];

    always @(posedge clk) begin
        if (ram_wr_o) ram[ram_a_o[7:0]] <= ram_dout_o;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h00] = 8'h13;
        ram[8'h04] = 8'hB7;
        ram[8'h05] = 8'h02;
        ram[8'h13] = 8'hAB;

        // reset state
        #12;
        check("rst_ram_a", ram_a_o, 32'h0);
        check("rst_ram_wr", {31'b0, ram_wr_o}, 32'h0);
        check("rst_if_done", {31'b0, if_done_o}, 32'h0);
        check("rst_mem_done", {31'b0, mem_done_o}, 32'h0);
        check("rst_if_data", if_data_o, 32'h0);
        rst = 1'b0;
        tick();

        // 1: 4-byte fetch at 0x1000, done 5 edges after accept
        if_req_i = 1'b1; if_addr_i = 32'h0000_1000;
        tick();
        check("f1_a0", ram_a_o, 32'h1000);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("f1_addr", ram_a_o, 32'h1000 + k);
            check("f1_nodone", {31'b0, if_done_o}, 32'h0);
        end
        tick();
        check("f1_nodone4", {31'b0, if_done_o}, 32'h0);
        tick();
        check("f1_done", {31'b0, if_done_o}, 32'h1);
        check("f1_data", if_data_o, 32'h0000_0013);
        if_req_i = 1'b0;
        tick();
        check("f1_pulse", {31'b0, if_done_o}, 32'h0);

        // 2: lb and fetch together, MEM wins, IF after MEM done cycle
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = LEN_B; mem_addr_i = 32'h2013;
        if_req_i = 1'b1; if_addr_i = 32'h1000;
        tick();
        check("arb_a", ram_a_o, 32'h2013);
        tick();
        tick();
        check("lb_done", {31'b0, mem_done_o}, 32'h1);
        check("lb_data", mem_rdata_o, 32'h0000_00AB);
        check("lb_if_wait", {31'b0, if_done_o}, 32'h0);
        mem_req_i = 1'b0;
        tick();
        check("done_cycle_idle", ram_a_o, 32'h0);
        tick();
        check("if_after_mem", ram_a_o, 32'h1000);
        for (int k = 0; k < 4; k++) tick();
        tick();
        check("f2_done", {31'b0, if_done_o}, 32'h1);
        check("f2_data", if_data_o, 32'h0000_0013);
        if_req_i = 1'b0;
        tick();

        // 3: sw 0x11223344 at 0x3020, then lh at 0x3021
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = LEN_W;
        mem_addr_i = 32'h3020; mem_wdata_i = 32'h1122_3344;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("sw_addr", ram_a_o, 32'h3020 + k);
            check("sw_data", {24'b0, ram_dout_o}, (32'h1122_3344 >> (8 * k)) & 32'hFF);
            check("sw_wr", {31'b0, ram_wr_o}, 32'h1);
            check("sw_nodone", {31'b0, mem_done_o}, 32'h0);
        end
        tick();
        check("sw_done", {31'b0, mem_done_o}, 32'h1);
        check("sw_wr_off", {31'b0, ram_wr_o}, 32'h0);
        check("sw_idle_a", ram_a_o, 32'h0);
        mem_req_i = 1'b0;
        tick();
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = LEN_H; mem_addr_i = 32'h3021;
        tick();
        check("lh_a0", ram_a_o, 32'h3021);
        tick();
        check("lh_a1", ram_a_o, 32'h3022);
        tick();
        check("lh_nodone", {31'b0, mem_done_o}, 32'h0);
        tick();
        check("lh_done", {31'b0, mem_done_o}, 32'h1);
        check("lh_data", mem_rdata_o, 32'h0000_2233);
        mem_req_i = 1'b0;
        tick();

        // 4: flush at byte 2 aborts, new fetch accepted next IDLE cycle
        if_req_i = 1'b1; if_addr_i = 32'h1000;
        tick();
        tick();
        tick();
        check("fl_a2", ram_a_o, 32'h1002);
        if_flush_i = 1'b1;
        tick();
        check("fl_a_zero", ram_a_o, 32'h0);
        check("fl_nodone", {31'b0, if_done_o}, 32'h0);
        if_flush_i = 1'b0; if_addr_i = 32'h1004;
        tick();
        check("fl_refetch", ram_a_o, 32'h1004);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fl_nodone2", {31'b0, if_done_o}, 32'h0);
        end
        tick();
        check("fl_done", {31'b0, if_done_o}, 32'h1);
        check("fl_data", if_data_o, 32'h0000_02B7);
        if_req_i = 1'b0;
        tick();
        // flush in IDLE blocks IF, but not a MEM load
        if_req_i = 1'b1; if_flush_i = 1'b1;
        tick();
        check("fl_idle_block", ram_a_o, 32'h0);
        if_req_i = 1'b0;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = LEN_B; mem_addr_i = 32'h2013;
        tick();
        check("fl_mem_acc", ram_a_o, 32'h2013);
        tick();
        tick();
        check("fl_mem_done", {31'b0, mem_done_o}, 32'h1);
        check("fl_mem_data", mem_rdata_o, 32'h0000_00AB);
        mem_req_i = 1'b0; if_flush_i = 1'b0;
        tick();

        // 5: IO-region store with the IO buffer full
        io_full_i = 1'b1;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = LEN_B;
        mem_addr_i = 32'h0003_0000; mem_wdata_i = 32'h0000_005A;
`ifdef MEMCTRL_IO_STALL_EN
        for (int k = 0; k < 10; k++) begin
            tick();
            check("io_stall_wr", {31'b0, ram_wr_o}, 32'h0);
        end
        io_full_i = 1'b0;
        tick();
`else
        tick();
`endif
        check("io_wr", {31'b0, ram_wr_o}, 32'h1);
        check("io_addr", ram_a_o, 32'h0003_0000);
        check("io_data", {24'b0, ram_dout_o}, 32'h5A);
        tick();
        check("io_done", {31'b0, mem_done_o}, 32'h1);
        check("io_wr_off", {31'b0, ram_wr_o}, 32'h0);
        mem_req_i = 1'b0; io_full_i = 1'b0;
        tick();

        // 6: address wrap and reset mid-read
        if_req_i = 1'b1; if_addr_i = 32'hFFFF_FFFE;
        tick();
        check("wrap_a0", ram_a_o, 32'hFFFF_FFFE);
        tick();
        check("wrap_a1", ram_a_o, 32'hFFFF_FFFF);
        tick();
        check("wrap_a2", ram_a_o, 32'h0000_0000);
        tick();
        check("wrap_a3", ram_a_o, 32'h0000_0001);
        #2 rst = 1'b1;
        #1;
        check("arst_a", ram_a_o, 32'h0);
        check("arst_if_done", {31'b0, if_done_o}, 32'h0);
        check("arst_if_data", if_data_o, 32'h0);
        check("arst_mem_rdata", mem_rdata_o, 32'h0);
        if_req_i = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("arst_nodone", {31'b0, if_done_o}, 32'h0);
        end
        if_req_i = 1'b1; if_addr_i = 32'h1020;
        tick();
        check("reissue_a", ram_a_o, 32'h1020);
        for (int k = 0; k < 4; k++) tick();
        tick();
        check("reissue_done", {31'b0, if_done_o}, 32'h1);
        check("reissue_data", if_data_o, 32'h1122_3344);
        if_req_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
